// File: rtl/mem2axi_if.sv
// mem2axi_if -- AXI4 bus bundle between the mem2axi bridge and an AXI target.
//
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH.
// Channels:   AW, W, B, AR, R (full AXI4 signal set, 1-bit user fields).
// Modports:   master (initiator side), slave (target side).
interface mem2axi_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 10
);
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic [1:0]                  aw_burst;
   logic                        aw_lock;
   logic [3:0]                  aw_cache;
   logic [2:0]                  aw_prot;
   logic [3:0]                  aw_qos;
   logic [3:0]                  aw_region;
   logic                        aw_user;
   logic                        aw_valid;
   logic                        aw_ready;

   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic                        w_user;
   logic                        w_valid;
   logic                        w_ready;

   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic                        b_user;
   logic                        b_valid;
   logic                        b_ready;

   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic [1:0]                  ar_burst;
   logic                        ar_lock;
   logic [3:0]                  ar_cache;
   logic [2:0]                  ar_prot;
   logic [3:0]                  ar_qos;
   logic [3:0]                  ar_region;
   logic                        ar_user;
   logic                        ar_valid;
   logic                        ar_ready;

   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic                        r_user;
   logic                        r_valid;
   logic                        r_ready;

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
             aw_prot, aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
             ar_prot, ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
             aw_prot, aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
             ar_prot, ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/mem2axi.sv
// mem2axi -- bridges a simple 32-bit core memory port onto a 64-bit AXI4
// initiator. One single-beat transaction is outstanding at a time.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   mem_req_i     request valid; mem_gnt_o accepts it (combinational, IDLE only)
//   mem_addr_i    word-aligned byte address; addr[2] selects the 32-bit lane
//   mem_we_i      1 = write, 0 = read
//   mem_be_i      write byte enables
//   mem_wdata_i   write data
//   mem_rvalid_o  one-cycle completion pulse for reads and writes
//   mem_rdata_o   read data, valid with mem_rvalid_o
//   mem_err_o     error flag, valid with mem_rvalid_o
//   master        AXI4 initiator port (mem2axi_if.master)
//
// Optional feature: define MEM2AXI_ERR_EN to report SLVERR/DECERR on
// mem_err_o; otherwise mem_err_o is tied low and no response is stored.
module mem2axi #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ID         = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_req_i,
   input  logic [AXI_ADDR_WIDTH-1:0] mem_addr_i,
   input  logic                      mem_we_i,
   input  logic [3:0]                mem_be_i,
   input  logic [31:0]               mem_wdata_i,
   output logic                      mem_gnt_o,
   output logic                      mem_rvalid_o,
   output logic [31:0]               mem_rdata_o,
   output logic                      mem_err_o,
   mem2axi_if.master                 master
);
   localparam int HALF = AXI_DATA_WIDTH / 2;

   typedef enum logic [2:0] {IDLE, AR, R_WAIT, AW_W, B_WAIT, RESP} state_t;

   state_t                    state;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic                      we_q;
   logic [3:0]                be_q;
   logic [31:0]               wdata_q;
   logic                      ar_valid_q;
   logic                      aw_valid_q;
   logic                      w_valid_q;
   logic                      r_ready_q;
   logic                      b_ready_q;
   logic                      rvalid_q;
   logic [31:0]               rdata_q;
`ifdef MEM2AXI_ERR_EN
   logic [1:0]                resp_q;
`endif

   // A write channel counts as finished when it was already handshaken
   // earlier or is handshaking now; both must be finished to leave AW_W.
   logic aw_ok;
   logic w_ok;
   assign aw_ok = !aw_valid_q || master.aw_ready;
   assign w_ok  = !w_valid_q  || master.w_ready;

   assign mem_gnt_o    = (state == IDLE) && mem_req_i && !rst;
   assign mem_rvalid_o = rvalid_q;
   assign mem_rdata_o  = rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         ar_valid_q <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         r_ready_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
`ifdef MEM2AXI_ERR_EN
         resp_q     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (mem_req_i) begin
                  addr_q  <= mem_addr_i;
                  we_q    <= mem_we_i;
                  be_q    <= mem_be_i;
                  wdata_q <= mem_wdata_i;
                  if (mem_we_i) begin
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state      <= AW_W;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state      <= AR;
                  end
               end
            end
            AR: begin
               if (master.ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state      <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (master.r_valid && !we_q) begin
                  r_ready_q <= 1'b0;
                  rdata_q   <= addr_q[2] ? master.r_data[AXI_DATA_WIDTH-1:HALF]
                                         : master.r_data[HALF-1:0];
`ifdef MEM2AXI_ERR_EN
                  resp_q    <= master.r_resp;
`endif
                  rvalid_q  <= 1'b1;
                  state     <= RESP;
               end
            end
            AW_W: begin
               if (master.aw_ready) aw_valid_q <= 1'b0;
               if (master.w_ready)  w_valid_q  <= 1'b0;
               if (aw_ok && w_ok) begin
                  b_ready_q <= 1'b1;
                  state     <= B_WAIT;
               end
            end
            B_WAIT: begin
               if (master.b_valid) begin
                  b_ready_q <= 1'b0;
`ifdef MEM2AXI_ERR_EN
                  resp_q    <= master.b_resp;
`endif
                  rvalid_q  <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               rvalid_q <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // SLVERR (2'b10) and DECERR (2'b11) both have resp[1] set.
`ifdef MEM2AXI_ERR_EN
   assign mem_err_o = rvalid_q && resp_q[1];
`else
   assign mem_err_o = 1'b0;
`endif

   // Response IDs, last and user fields are deliberately ignored.
   logic unused_ok;
`ifdef MEM2AXI_ERR_EN
   assign unused_ok = ^{master.r_id, master.r_last, master.r_user,
                        master.b_id, master.b_user};
`else
   assign unused_ok = ^{master.r_id, master.r_last, master.r_user, master.r_resp,
                        master.b_id, master.b_user, master.b_resp};
`endif

   assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
   assign master.ar_addr   = addr_q;
   assign master.ar_len    = 8'd0;
   assign master.ar_size   = 3'b010;
   assign master.ar_burst  = 2'b01;
   assign master.ar_lock   = 1'b0;
   assign master.ar_cache  = 4'd0;
   assign master.ar_prot   = 3'd0;
   assign master.ar_qos    = 4'd0;
   assign master.ar_region = 4'd0;
   assign master.ar_user   = 1'b0;
   assign master.ar_valid  = ar_valid_q;
   assign master.r_ready   = r_ready_q;

   assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
   assign master.aw_addr   = addr_q;
   assign master.aw_len    = 8'd0;
   assign master.aw_size   = 3'b010;
   assign master.aw_burst  = 2'b01;
   assign master.aw_lock   = 1'b0;
   assign master.aw_cache  = 4'd0;
   assign master.aw_prot   = 3'd0;
   assign master.aw_qos    = 4'd0;
   assign master.aw_region = 4'd0;
   assign master.aw_user   = 1'b0;
   assign master.aw_valid  = aw_valid_q;

   // The 32-bit word is replicated on both lanes; the strobe picks the lane.
   assign master.w_data    = {wdata_q, wdata_q};
   assign master.w_strb    = addr_q[2] ? {be_q, 4'b0000} : {4'b0000, be_q};
   assign master.w_last    = 1'b1;
   assign master.w_user    = 1'b0;
   assign master.w_valid   = w_valid_q;
   assign master.b_ready   = b_ready_q;
endmodule

// File: tb/tb_mem2axi.sv
// tb_mem2axi -- directed self-checking bench for mem2axi. A configurable AXI
// target answers the bridge; a per-cycle checker compares the DUT against a
// transaction-level model, and each directed test pins literal results.
module tb_mem2axi;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 10;
`ifdef MEM2AXI_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_req_i = 1'b0;
   logic [AW-1:0] mem_addr_i = '0;
   logic          mem_we_i = 1'b0;
   logic [3:0]    mem_be_i = '0;
   logic [31:0]   mem_wdata_i = '0;
   logic          mem_gnt_o;
   logic          mem_rvalid_o;
   logic [31:0]   mem_rdata_o;
   logic          mem_err_o;

   mem2axi_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

   mem2axi #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ID(0)) dut (
      .clk(clk), .rst(rst),
      .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i),
      .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
      .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o),
      .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
      .master(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Target configuration
   int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [63:0] cfg_rdata = '0;
   logic [1:0]  cfg_resp = 2'b00;
   bit          rdy_always = 1'b0;

   // AXI target: drives on the falling edge; handshakes take effect on the
   // following rising edge and are remembered for the next falling edge.
   initial begin
      bit pend_r, pend_b, aw_done, w_done;
      bit hs_ar, hs_r, hs_aw, hs_w, hs_b;
      int ar_c, r_c, aw_c, w_c, b_c;
      {pend_r, pend_b, aw_done, w_done, hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
      {ar_c, r_c, aw_c, w_c, b_c} = '0;
      bus.ar_ready = 0; bus.aw_ready = 0; bus.w_ready = 0;
      bus.r_valid = 0; bus.r_data = '0; bus.r_resp = 0; bus.r_id = '1;
      bus.r_last = 1; bus.r_user = 0;
      bus.b_valid = 0; bus.b_resp = 0; bus.b_id = '1; bus.b_user = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            {pend_r, pend_b, aw_done, w_done, hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
            {ar_c, r_c, aw_c, w_c, b_c} = '0;
            bus.ar_ready = 0; bus.aw_ready = 0; bus.w_ready = 0;
            bus.r_valid = 0; bus.b_valid = 0;
         end else begin
            if (hs_ar) begin pend_r = 1; r_c = 0; end
            if (hs_r) pend_r = 0;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            if (aw_done && w_done) begin pend_b = 1; b_c = 0; aw_done = 0; w_done = 0; end
            if (hs_b) pend_b = 0;
            bus.ar_ready = rdy_always || (bus.ar_valid && ar_c >= ar_dly);
            ar_c = bus.ar_valid ? ar_c + 1 : 0;
            bus.aw_ready = rdy_always || (bus.aw_valid && aw_c >= aw_dly);
            aw_c = bus.aw_valid ? aw_c + 1 : 0;
            bus.w_ready = rdy_always || (bus.w_valid && w_c >= w_dly);
            w_c = bus.w_valid ? w_c + 1 : 0;
            bus.r_valid = pend_r && r_c >= r_dly;
            bus.r_data = cfg_rdata;
            bus.r_resp = cfg_resp;
            r_c = pend_r ? r_c + 1 : 0;
            bus.b_valid = pend_b && b_c >= b_dly;
            bus.b_resp = cfg_resp;
            b_c = pend_b ? b_c + 1 : 0;
            hs_ar = bus.ar_valid && bus.ar_ready;
            hs_r  = bus.r_valid && bus.r_ready;
            hs_aw = bus.aw_valid && bus.aw_ready;
            hs_w  = bus.w_valid && bus.w_ready;
            hs_b  = bus.b_valid && bus.b_ready;
         end
      end
   end

   // Observations gathered by the checker for the directed tests
   int          n_ar, n_aw, n_w, n_b, n_rv, aw_hi, w_hi, gnt_cyc, rv_cyc, bready_cyc;
   logic [31:0] ar_addr_seen;
   logic [7:0]  strb_seen;
   logic [63:0] wdata_seen;
   logic [31:0] last_rdata;
   logic        last_err;
   int          gnt_q[$];
   int          rv_q[$];
   logic [31:0] rdata_hist[$];

   task automatic clear_stats();
      n_ar = 0; n_aw = 0; n_w = 0; n_b = 0; n_rv = 0; aw_hi = 0; w_hi = 0;
      gnt_cyc = -1; rv_cyc = -1; bready_cyc = -1;
      ar_addr_seen = '0; strb_seen = '0; wdata_seen = '0; last_rdata = '0; last_err = 0;
      gnt_q.delete(); rv_q.delete(); rdata_hist.delete();
   endtask

   // Transaction-level model: one request in flight, attributes fixed by the
   // accepted request, completion one cycle after the AXI response.
   initial begin
      bit          busy, resp_seen, exp_gnt;
      bit          c_we;
      logic [31:0] c_addr, c_wdata;
      logic [3:0]  c_be;
      logic [63:0] seen_rdata;
      logic [1:0]  seen_resp;
      bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
      busy = 0; resp_seen = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
      seen_rdata = '0; seen_resp = '0;
      {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            chk("reset outputs",
                {bus.ar_valid, bus.aw_valid, bus.w_valid, bus.r_ready, bus.b_ready,
                 mem_gnt_o, mem_rvalid_o, mem_err_o, mem_rdata_o}, '0);
            busy = 0; resp_seen = 0;
            {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} = '0;
         end else begin
            exp_gnt = mem_req_i && !busy;
            chk("grant", mem_gnt_o, exp_gnt);
            if (!busy)
               chk("idle quiet", {bus.ar_valid, bus.aw_valid, bus.w_valid,
                                  bus.r_ready, bus.b_ready, mem_rvalid_o}, '0);
            if (p_arv && !p_arr) chk("ar_valid held", bus.ar_valid, 1);
            if (p_awv && !p_awr) chk("aw_valid held", bus.aw_valid, 1);
            if (p_wv && !p_wr)   chk("w_valid held", bus.w_valid, 1);
            if (bus.ar_valid) begin
               chk("ar for read", {busy, c_we}, 2'b10);
               chk("ar_addr", bus.ar_addr, c_addr);
               chk("ar attrs", {bus.ar_id, bus.ar_len, bus.ar_size, bus.ar_burst, bus.ar_lock,
                                bus.ar_cache, bus.ar_prot, bus.ar_qos, bus.ar_region, bus.ar_user},
                   {10'd0, 8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
               if (bus.ar_ready) begin n_ar++; ar_addr_seen = bus.ar_addr; end
            end
            if (bus.aw_valid) begin
               aw_hi++;
               chk("aw for write", {busy, c_we}, 2'b11);
               chk("aw_addr", bus.aw_addr, c_addr);
               chk("aw attrs", {bus.aw_id, bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_lock,
                                bus.aw_cache, bus.aw_prot, bus.aw_qos, bus.aw_region, bus.aw_user},
                   {10'd0, 8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
               if (bus.aw_ready) n_aw++;
            end
            if (bus.w_valid) begin
               w_hi++;
               chk("w_data", bus.w_data, {c_wdata, c_wdata});
               chk("w_strb", bus.w_strb, c_addr[2] ? {c_be, 4'h0} : {4'h0, c_be});
               chk("w_last", bus.w_last, 1);
               if (bus.w_ready) begin n_w++; strb_seen = bus.w_strb; wdata_seen = bus.w_data; end
            end
            if (bus.b_ready && bready_cyc < 0) bready_cyc = cyc;
            if (bus.r_valid && bus.r_ready) begin
               resp_seen = 1; seen_rdata = bus.r_data; seen_resp = bus.r_resp;
            end
            if (bus.b_valid && bus.b_ready) begin
               resp_seen = 1; seen_resp = bus.b_resp; n_b++;
            end
            if (mem_rvalid_o) begin
               chk("rvalid after response", {busy, resp_seen}, 2'b11);
               if (!c_we)
                  chk("rdata", mem_rdata_o, c_addr[2] ? seen_rdata[63:32] : seen_rdata[31:0]);
               chk("err", mem_err_o, ERR_EN && seen_resp[1]);
               n_rv++; rv_cyc = cyc; rv_q.push_back(cyc);
               last_rdata = mem_rdata_o; last_err = mem_err_o; rdata_hist.push_back(mem_rdata_o);
               busy = 0; resp_seen = 0;
            end
            if (exp_gnt) begin
               busy = 1; c_we = mem_we_i; c_addr = mem_addr_i; c_be = mem_be_i; c_wdata = mem_wdata_i;
               gnt_cyc = cyc; gnt_q.push_back(cyc);
            end
            p_arv = bus.ar_valid; p_arr = bus.ar_ready;
            p_awv = bus.aw_valid; p_awr = bus.aw_ready;
            p_wv  = bus.w_valid;  p_wr  = bus.w_ready;
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
      bit got;
      got = 0;
      @(negedge clk);
      mem_req_i = 1; mem_we_i = we; mem_addr_i = a; mem_be_i = be; mem_wdata_i = wd;
      for (int i = 0; i < 50; i++) begin
         #3;
         if (mem_gnt_o) begin got = 1; break; end
         @(negedge clk);
      end
      if (!got) chk("grant timeout", 0, 1);
      @(negedge clk);
      mem_req_i = 0;
   endtask

   task automatic wait_rv(input int target);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #3;
         if (n_rv >= target) return;
      end
      chk("completion timeout", n_rv, target);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      clear_stats();
      idle(3);
      chk("reset rdata", mem_rdata_o, 32'h0);
      rst = 0;

      // Read, lane select high word, immediate ready, OKAY
      clear_stats();
      cfg_rdata = 64'hAABBCCDD_11223344; cfg_resp = 2'b00;
      issue(0, 32'h1004, 4'h0, 32'h0);
      wait_rv(1);
      idle(3);
      chk("t1 rdata", last_rdata, 32'hAABBCCDD);
      chk("t1 ar count", n_ar, 1);
      chk("t1 ar addr", ar_addr_seen, 32'h1004);
      chk("t1 rvalid count", n_rv, 1);
      chk("t1 latency", rv_cyc - gnt_cyc, 3);

      // Write, low lane, aw_ready held off 3 cycles
      clear_stats();
      aw_dly = 3;
      issue(1, 32'h2000, 4'b0011, 32'h0000BEEF);
      wait_rv(1);
      idle(3);
      aw_dly = 0;
      chk("t2 strb", strb_seen, 8'h03);
      chk("t2 wdata", wdata_seen, 64'h0000BEEF_0000BEEF);
      chk("t2 w_valid cycles", w_hi, 1);
      chk("t2 aw_valid cycles", aw_hi, 4);
      chk("t2 b count", n_b, 1);
      chk("t2 rvalid count", n_rv, 1);

      // Write, high lane, both handshakes in the same cycle
      clear_stats();
      issue(1, 32'h2004, 4'hF, 32'hCAFEF00D);
      wait_rv(1);
      idle(3);
      chk("t3 strb", strb_seen, 8'hF0);
      chk("t3 aw/w cycles", {aw_hi[7:0], w_hi[7:0]}, 16'h0101);
      chk("t3 b_ready cycle", bready_cyc - gnt_cyc, 2);
      chk("t3 rvalid count", n_rv, 1);

      // Back-to-back reads with mem_req_i held high
      clear_stats();
      cfg_rdata = 64'h5555AAAA_12345678;
      @(negedge clk);
      mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h3000;
      for (int i = 0; i < 20 && gnt_q.size() < 1; i++) @(negedge clk);
      mem_addr_i = 32'h3004;
      for (int i = 0; i < 40 && gnt_q.size() < 2; i++) begin #3; if (gnt_q.size() < 2) @(negedge clk); end
      @(negedge clk);
      mem_req_i = 0;
      wait_rv(2);
      idle(3);
      chk("t4 grants", gnt_q.size(), 2);
      chk("t4 completions", rv_q.size(), 2);
      if (gnt_q.size() == 2 && rv_q.size() == 2) begin
         chk("t4 second grant cycle", gnt_q[1] - rv_q[0], 1);
         chk("t4 rdata0", rdata_hist[0], 32'h12345678);
         chk("t4 rdata1", rdata_hist[1], 32'h5555AAAA);
      end

      // Read answered with SLVERR after a delay
      clear_stats();
      cfg_rdata = 64'h0; cfg_resp = 2'b10; r_dly = 2;
      issue(0, 32'h1000, 4'h0, 32'h0);
      wait_rv(1);
      idle(3);
      chk("t5 err", last_err, ERR_EN);
      cfg_resp = 2'b11;
      issue(1, 32'h1008, 4'h1, 32'h5A);
      wait_rv(2);
      idle(3);
      chk("t5 decerr write", last_err, ERR_EN);
      cfg_resp = 2'b00; r_dly = 0;

      // Readies already high while idle
      clear_stats();
      rdy_always = 1;
      idle(2);
      issue(0, 32'h100C, 4'h0, 32'h0);
      wait_rv(1);
      idle(3);
      rdy_always = 0;
      chk("t6 ar count", n_ar, 1);
      chk("t6 rvalid count", n_rv, 1);

      // Reset while ar_valid is high
      clear_stats();
      ar_dly = 10;
      issue(0, 32'h4000, 4'h0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #3;
         if (bus.ar_valid) break;
      end
      chk("t7 ar_valid before reset", bus.ar_valid, 1);
      #1 rst = 1;
      #1 chk("t7 ar_valid dropped", bus.ar_valid, 0);
      idle(2);
      rst = 0;
      ar_dly = 0;
      idle(4);
      chk("t7 no completion", n_rv, 0);
      cfg_rdata = 64'h0BADF00D_600DCAFE;
      issue(0, 32'h4000, 4'h0, 32'h0);
      wait_rv(1);
      idle(3);
      chk("t7 recovery rdata", last_rdata, 32'h600DCAFE);
      chk("t7 recovery count", n_rv, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
